// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job sequencer.
//   WIDTH           default prime width
//   MSG_W           message width for the default prime width (2*WIDTH)
//   rsa_seq_state_t sequencer FSM state encoding
package rsa_pkg;

    localparam int WIDTH = 128;
    localparam int MSG_W = 2 * WIDTH;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INV_PULSE = 3'd1,
        INV_WAIT  = 3'd2,
        EXP_PULSE = 3'd3,
        EXP_WAIT  = 3'd4,
        RESP      = 3'd5
    } rsa_seq_state_t;

endpackage

// File: rtl/rsa_seq_watchdog.sv
// Watchdog for the sequencer's wait states.
// Ports:
//   clk      system clock
//   reset    synchronous, active-high; clears the counter
//   clear    clears the counter (start of each wait phase)
//   enable   count one cycle
//   timeout  counter has reached TIMEOUT_CYCLES-1
// The counter saturates at its limit, so it never wraps even if the
// caller keeps it enabled after the timeout has been reported.
module rsa_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/rsa_job_sequencer.sv
// Front-end sequencer for the RSA control core.
// Accepts a job (p, q, direction, message), runs the core's inverter
// phase (skipped when the key pair matches the cached one), then its
// mod_exp phase, and returns the result. A watchdog converts a hung
// core into an error response.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/req_ready              job request handshake
//   req_p, req_q, req_encrypt_decrypt, req_msg   job fields
//   p, q, encrypt_decrypt, msg_in    operand buses to the core (held per job)
//   reset_inverter, reset_mod_exp    one-cycle start pulses to the core
//   inverter_finish, mod_exp_finish  completion levels from the core
//   msg_out                          result bus from the core
//   rsp_valid/rsp_ready              response handshake
//   rsp_msg, rsp_error               result, or 0 with error=1 on timeout
//
// state     | meaning
// IDLE      | ready for a job
// INV_PULSE | reset_inverter high for one cycle
// INV_WAIT  | waiting on inverter_finish (first cycle ignored)
// EXP_PULSE | reset_mod_exp high for one cycle
// EXP_WAIT  | waiting on mod_exp_finish (first cycle ignored)
// RESP      | response held until accepted
module rsa_job_sequencer #(
    parameter int WIDTH          = rsa_pkg::WIDTH,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int KEY_CACHE      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_p,
    input  logic [WIDTH-1:0]     req_q,
    input  logic                 req_encrypt_decrypt,
    input  logic [2*WIDTH-1:0]   req_msg,
    output logic [WIDTH-1:0]     p,
    output logic [WIDTH-1:0]     q,
    output logic                 encrypt_decrypt,
    output logic [2*WIDTH-1:0]   msg_in,
    output logic                 reset_inverter,
    output logic                 reset_mod_exp,
    input  logic                 inverter_finish,
    input  logic                 mod_exp_finish,
    input  logic [2*WIDTH-1:0]   msg_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_msg,
    output logic                 rsp_error
);

    import rsa_pkg::*;

    rsa_seq_state_t   state;
    logic             first_wait;
    logic             cache_valid;
    logic [WIDTH-1:0] cached_p;
    logic [WIDTH-1:0] cached_q;
    logic             cache_hit;
    logic             timeout;
    logic             wd_clear;
    logic             wd_enable;

    assign cache_hit = (KEY_CACHE != 0) && cache_valid &&
                       (req_p == cached_p) && (req_q == cached_q);

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Gated by reset so a pulse cannot reach the core in the cycle a
    // mid-job reset is asserted.
    assign reset_inverter = (state == INV_PULSE) && !reset;
    assign reset_mod_exp  = (state == EXP_PULSE) && !reset;

    assign wd_clear  = (state == INV_PULSE) || (state == EXP_PULSE);
    assign wd_enable = (state == INV_WAIT)  || (state == EXP_WAIT);

    rsa_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            p               <= '0;
            q               <= '0;
            encrypt_decrypt <= 1'b0;
            msg_in          <= '0;
            rsp_msg         <= '0;
            rsp_error       <= 1'b0;
            cache_valid     <= 1'b0;
            cached_p        <= '0;
            cached_q        <= '0;
            first_wait      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        p               <= req_p;
                        q               <= req_q;
                        encrypt_decrypt <= req_encrypt_decrypt;
                        msg_in          <= req_msg;
                        state           <= cache_hit ? EXP_PULSE : INV_PULSE;
                    end
                end
                INV_PULSE: begin
                    first_wait <= 1'b1;
                    state      <= INV_WAIT;
                end
                INV_WAIT: begin
                    // The finish level seen in the first wait cycle is
                    // left over from the previous operation.
                    first_wait <= 1'b0;
                    if (!first_wait && inverter_finish) begin
                        cached_p    <= p;
                        cached_q    <= q;
                        cache_valid <= 1'b1;
                        state       <= EXP_PULSE;
                    end else if (timeout) begin
                        rsp_error   <= 1'b1;
                        rsp_msg     <= '0;
                        cache_valid <= 1'b0;
                        state       <= RESP;
                    end
                end
                EXP_PULSE: begin
                    first_wait <= 1'b1;
                    state      <= EXP_WAIT;
                end
                EXP_WAIT: begin
                    first_wait <= 1'b0;
                    if (!first_wait && mod_exp_finish) begin
                        rsp_msg   <= msg_out;
                        rsp_error <= 1'b0;
                        state     <= RESP;
                    end else if (timeout) begin
                        rsp_error   <= 1'b1;
                        rsp_msg     <= '0;
                        cache_valid <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Bench for rsa_job_sequencer. A behavioural stand-in for the RSA core
// answers the start pulses after fixed latencies; its "encryption" is an
// addition of {p,q} and decryption the matching subtraction, so a
// decrypt of an encrypt returns the original message. A second instance
// with a short watchdog and a core that never finishes mod_exp covers
// the timeout path.
module tb_rsa_job_sequencer;

    localparam int W         = 128;
    localparam int MW        = 2 * W;
    localparam int INV_LAT   = 40;
    localparam int EXP_LAT   = 300;
    localparam int MAIN_TO   = 4096;
    localparam int TO_CYC    = 64;
    localparam int T_INV_LAT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_p = '0;
    logic [W-1:0]  req_q = '0;
    logic          req_encrypt_decrypt = 1'b0;
    logic [MW-1:0] req_msg = '0;
    logic [W-1:0]  p, q;
    logic          encrypt_decrypt;
    logic [MW-1:0] msg_in;
    logic          reset_inverter, reset_mod_exp;
    logic          inverter_finish = 1'b0;
    logic          mod_exp_finish = 1'b0;
    logic [MW-1:0] msg_out = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [MW-1:0] rsp_msg;
    logic          rsp_error;

    logic          t_req_valid = 1'b0;
    logic          t_req_ready;
    logic [W-1:0]  t_p, t_q;
    logic          t_encrypt_decrypt;
    logic [MW-1:0] t_msg_in;
    logic          t_reset_inverter, t_reset_mod_exp;
    logic          t_inv_fin = 1'b0;
    logic [MW-1:0] t_msg_out = '1;
    logic          t_rsp_valid;
    logic          t_rsp_ready = 1'b0;
    logic [MW-1:0] t_rsp_msg;
    logic          t_rsp_error;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int job_no  = 0;

    // key cache as the bench expects it to be
    logic          bc_valid = 1'b0;
    logic [W-1:0]  bc_p = '0, bc_q = '0;

    rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(MAIN_TO), .KEY_CACHE(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_p(req_p), .req_q(req_q), .req_encrypt_decrypt(req_encrypt_decrypt), .req_msg(req_msg),
        .p(p), .q(q), .encrypt_decrypt(encrypt_decrypt), .msg_in(msg_in),
        .reset_inverter(reset_inverter), .reset_mod_exp(reset_mod_exp),
        .inverter_finish(inverter_finish), .mod_exp_finish(mod_exp_finish), .msg_out(msg_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_msg(rsp_msg), .rsp_error(rsp_error)
    );

    rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO_CYC), .KEY_CACHE(1)) dut_to (
        .clk(clk), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_p(req_p), .req_q(req_q), .req_encrypt_decrypt(req_encrypt_decrypt), .req_msg(req_msg),
        .p(t_p), .q(t_q), .encrypt_decrypt(t_encrypt_decrypt), .msg_in(t_msg_in),
        .reset_inverter(t_reset_inverter), .reset_mod_exp(t_reset_mod_exp),
        .inverter_finish(t_inv_fin), .mod_exp_finish(1'b0), .msg_out(t_msg_out),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_msg(t_rsp_msg), .rsp_error(t_rsp_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [MW-1:0] rand256();
        logic [MW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [MW-1:0] core_result(input logic [W-1:0] kp, input logic [W-1:0] kq,
                                                  input logic ed, input logic [MW-1:0] m);
        return ed ? (m - {kp, kq}) : (m + {kp, kq});
    endfunction

    // Core model: finish stays high until one cycle after the next start
    // pulse, so every wait phase begins with a stale finish level.
    int            inv_cd = 0, exp_cd = 0;
    logic [W-1:0]  m_p = '0, m_q = '0;
    logic          m_ed = 1'b0;
    logic [MW-1:0] m_msg = '0;
    always @(posedge clk) begin
        if (reset_inverter) begin
            inv_cd <= INV_LAT;
        end else if (inv_cd != 0) begin
            inv_cd          <= inv_cd - 1;
            inverter_finish <= (inv_cd == 1);
        end
        if (reset_mod_exp) begin
            exp_cd <= EXP_LAT;
            m_p    <= p;
            m_q    <= q;
            m_ed   <= encrypt_decrypt;
            m_msg  <= msg_in;
        end else if (exp_cd != 0) begin
            exp_cd         <= exp_cd - 1;
            mod_exp_finish <= (exp_cd == 1);
            msg_out        <= (exp_cd == 1) ? core_result(m_p, m_q, m_ed, m_msg) : rand256();
        end
    end

    int t_cd = 0;
    always @(posedge clk) begin
        if (t_reset_inverter) begin
            t_cd      <= T_INV_LAT;
            t_inv_fin <= 1'b0;
        end else if (t_cd != 0) begin
            t_cd      <= t_cd - 1;
            t_inv_fin <= (t_cd == 1);
        end
    end

    int inv_cnt = 0, exp_cnt = 0, inv_cyc = -1, exp_cyc = -1, overlap = 0;
    int t_inv_cnt = 0, t_exp_cnt = 0, t_exp_cyc = -1;
    always @(negedge clk) begin
        if (reset_inverter) begin inv_cnt <= inv_cnt + 1; inv_cyc <= cyc; end
        if (reset_mod_exp)  begin exp_cnt <= exp_cnt + 1; exp_cyc <= cyc; end
        if (reset_inverter && reset_mod_exp) overlap <= overlap + 1;
        if (t_reset_inverter) t_inv_cnt <= t_inv_cnt + 1;
        if (t_reset_mod_exp) begin t_exp_cnt <= t_exp_cnt + 1; t_exp_cyc <= cyc; end
        if (t_reset_inverter && t_reset_mod_exp) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_i(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Enter and leave on a negedge with the DUT idle.
    task automatic run_job(input logic [W-1:0] jp, input logic [W-1:0] jq, input logic jed,
                           input logic [MW-1:0] jm, input int hold, output logic [MW-1:0] res);
        logic          hit;
        logic [MW-1:0] exp_msg;
        int            inv0, exp0, c_acc, bad;
        string         t;
        job_no++;
        t       = $sformatf("job%0d", job_no);
        hit     = bc_valid && (jp == bc_p) && (jq == bc_q);
        exp_msg = core_result(jp, jq, jed, jm);
        inv0    = inv_cnt;
        exp0    = exp_cnt;
        req_p = jp; req_q = jq; req_encrypt_decrypt = jed; req_msg = jm; req_valid = 1'b1;
        check({t, "_req_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        c_acc = cyc;
        check({t, "_p"}, p, jp);
        check({t, "_q"}, q, jq);
        check({t, "_enc_dec"}, encrypt_decrypt, jed);
        check({t, "_msg_in"}, msg_in, jm);
        for (int i = 0; i < 2000 && rsp_valid !== 1'b1; i++) @(negedge clk);
        check({t, "_rsp_valid"}, rsp_valid, 1);
        check_i({t, "_rsp_cycle"}, cyc - c_acc, hit ? EXP_LAT + 2 : INV_LAT + EXP_LAT + 4);
        check_i({t, "_inv_pulses"}, inv_cnt - inv0, hit ? 0 : 1);
        check_i({t, "_exp_pulses"}, exp_cnt - exp0, 1);
        check_i({t, "_exp_pulse_at"}, exp_cyc - c_acc, hit ? 0 : INV_LAT + 2);
        if (!hit) check_i({t, "_inv_pulse_at"}, inv_cyc - c_acc, 0);
        check({t, "_rsp_msg"}, rsp_msg, exp_msg);
        check({t, "_rsp_error"}, rsp_error, 0);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (rsp_msg !== exp_msg || rsp_valid !== 1'b1 || req_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        check_i({t, "_hold_stable"}, bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({t, "_rsp_released"}, rsp_valid, 0);
        check({t, "_back_to_idle"}, req_ready, 1);
        bc_valid = 1'b1;
        bc_p     = jp;
        bc_q     = jq;
        res      = exp_msg;
    endtask

    task automatic run_to_job(input logic [W-1:0] jp, input logic [W-1:0] jq, input string t);
        int inv0, exp0, c_acc;
        inv0 = t_inv_cnt;
        exp0 = t_exp_cnt;
        req_p = jp; req_q = jq; req_encrypt_decrypt = 1'b0; req_msg = rand256();
        t_req_valid = 1'b1;
        check({t, "_req_ready"}, t_req_ready, 1);
        @(negedge clk);
        t_req_valid = 1'b0;
        c_acc = cyc;
        for (int i = 0; i < 300 && t_rsp_valid !== 1'b1; i++) @(negedge clk);
        check({t, "_rsp_valid"}, t_rsp_valid, 1);
        check_i({t, "_inv_pulses"}, t_inv_cnt - inv0, 1);
        check_i({t, "_exp_pulses"}, t_exp_cnt - exp0, 1);
        check_i({t, "_exp_pulse_at"}, t_exp_cyc - c_acc, T_INV_LAT + 2);
        check_i({t, "_rsp_after_exp"}, cyc - t_exp_cyc, TO_CYC + 1);
        check({t, "_rsp_error"}, t_rsp_error, 1);
        check({t, "_rsp_msg"}, t_rsp_msg, 0);
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
        check({t, "_back_to_idle"}, t_req_ready, 1);
    endtask

    initial begin
        logic [W-1:0]  kp [3];
        logic [W-1:0]  kq [3];
        logic [MW-1:0] m1, r1, r2, r_dummy;
        int            e0;

        kp[0] = 128'd113680897410347;
        kq[0] = 128'd7999808077935876437321;
        kp[1] = kq[0];
        kq[1] = kp[0];
        r_dummy = rand256();
        kp[2] = r_dummy[W-1:0];
        kq[2] = r_dummy[MW-1:W];

        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_error", rsp_error, 0);
        check("reset_rsp_msg", rsp_msg, 0);
        check("reset_pulses", {reset_inverter, reset_mod_exp}, 0);
        check("reset_operands", {p, q, encrypt_decrypt}, 0);
        reset = 1'b0;
        @(negedge clk);

        // first job: full inverter + mod_exp
        m1 = 256'h6a3e18f03ab37b0000000000;
        run_job(kp[0], kq[0], 1'b0, m1, 0, r1);
        // same key, decrypt the result: cache hit, original message back
        run_job(kp[0], kq[0], 1'b1, r1, 2, r2);
        check("roundtrip_msg", rsp_msg, m1);
        // swapped key pair is a miss
        run_job(kp[1], kq[1], 1'b0, rand256(), 0, r_dummy);
        // back-pressure for 20 cycles on a hit
        run_job(kp[1], kq[1], 1'b1, rand256(), 20, r_dummy);

        // reset in the INV_PULSE cycle suppresses the pulse immediately
        req_p = kp[0]; req_q = kq[0]; req_msg = rand256(); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstp_pulse_before", reset_inverter, 1);
        reset = 1'b1;
        #1;
        check("rstp_pulse_gated", reset_inverter, 0);
        @(negedge clk);
        reset = 1'b0;
        bc_valid = 1'b0;
        check("rstp_req_ready", req_ready, 1);
        check("rstp_p", p, 0);

        // reset during INV_WAIT aborts the job with no response
        e0 = exp_cnt;
        req_p = kp[0]; req_q = kq[0]; req_msg = rand256(); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstw_req_ready", req_ready, 1);
        check("rstw_pulses", {reset_inverter, reset_mod_exp}, 0);
        check("rstw_rsp", {rsp_valid, rsp_error}, 0);
        check("rstw_rsp_msg", rsp_msg, 0);
        check("rstw_operands", {p, q, encrypt_decrypt}, 0);
        check("rstw_msg_in", msg_in, 0);
        repeat (60) @(negedge clk);
        check("rstw_no_response", rsp_valid, 0);
        check_i("rstw_no_exp_pulse", exp_cnt - e0, 0);

        // randomized jobs over a small key pool (cache cleared by reset)
        for (int j = 0; j < 8; j++) begin
            int k;
            k = $urandom_range(0, 2);
            run_job(kp[k], kq[k], 1'($urandom_range(0, 1)), rand256(), $urandom_range(0, 4), r_dummy);
        end

        // watchdog: mod_exp never finishes
        run_to_job(kp[0], kq[0], "to1");
        run_to_job(kp[0], kq[0], "to2");

        check_i("pulse_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_job_sequencer.md
Name: rsa_job_sequencer

Overview:
- Upstream front-end for the RSA `control` core.
- Accepts RSA jobs (p, q, direction, message) over a valid/ready request channel.
- Drives control's operand buses and its reset_inverter / reset_mod_exp start pulses, waits on inverter_finish / mod_exp_finish, and returns msg_out on a valid/ready response channel.
- Caches the last key pair so repeated jobs with the same p/q skip the inverter phase; a watchdog turns a hung core into an error response.

Parameters:
- WIDTH, 128, prime width; message width is 2*WIDTH.
- TIMEOUT_CYCLES, 1048576, max cycles waiting on either finish before aborting.
- KEY_CACHE, 1, 1 = skip inverter phase when p/q match the cached key pair.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  job offered
- req_ready  out  1  sequencer can accept a job
- req_p  in  WIDTH  prime p
- req_q  in  WIDTH  prime q
- req_encrypt_decrypt  in  1  direction passed to core
- req_msg  in  2*WIDTH  input message
- p  out  WIDTH  to control p
- q  out  WIDTH  to control q
- encrypt_decrypt  out  1  to control
- msg_in  out  2*WIDTH  to control
- reset_inverter  out  1  one-cycle start pulse to control
- reset_mod_exp  out  1  one-cycle start pulse to control
- inverter_finish  in  1  from control
- mod_exp_finish  in  1  from control
- msg_out  in  2*WIDTH  from control
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_msg  out  2*WIDTH  result message
- rsp_error  out  1  1 = job aborted by timeout; rsp_msg = 0

Behaviour:
- Reset values: all outputs 0, except req_ready = 1 in IDLE. Reset also clears the key-cache valid bit and the timeout counter. Reset asserted mid-job aborts immediately: no response, start pulses forced 0 in that same cycle.
- Request handshake: a job is accepted on a clk edge with req_valid && req_ready. req_ready = 1 only in IDLE.
- On accept, req_* fields are registered into p, q, encrypt_decrypt, msg_in. These outputs stay stable until the next accept.
- FSM states: IDLE, INV_PULSE, INV_WAIT, EXP_PULSE, EXP_WAIT, RESP.
- IDLE -> accept:
  - If KEY_CACHE && cache_valid && req_p == cached_p && req_q == cached_q, go to EXP_PULSE.
  - Otherwise go to INV_PULSE.
- INV_PULSE: reset_inverter = 1 for exactly one cycle; timeout counter cleared. Next state INV_WAIT.
- INV_WAIT:
  - inverter_finish is ignored in the first INV_WAIT cycle (stale level from the previous operation). It is sampled from the second cycle on.
  - finish = 1 -> load cached_p/cached_q, set cache_valid, go to EXP_PULSE.
- EXP_PULSE: reset_mod_exp = 1 for exactly one cycle; counter cleared. Next state EXP_WAIT.
- EXP_WAIT:
  - Same first-cycle ignore rule, applied to mod_exp_finish.
  - finish = 1 -> rsp_msg <= msg_out captured that cycle, rsp_error <= 0, go to RESP.
- Timeout: in either WAIT state, the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without finish: rsp_error <= 1, rsp_msg <= 0, cache_valid <= 0, go to RESP. If finish and the timeout limit occur in the same cycle, finish wins.
- RESP: rsp_valid = 1. rsp_msg and rsp_error are held until rsp_valid && rsp_ready, then go to IDLE. Back-pressure of any length is allowed; the core is left idle meanwhile.
- Latency:
  - Accept to reset_inverter high: 1 cycle.
  - Finish seen to next pulse: 1 cycle.
  - mod_exp_finish seen to rsp_valid: 1 cycle.
- Never more than one start pulse high at a time. No pulses outside the PULSE states.
- Counter width: clog2(TIMEOUT_CYCLES)+1; it never wraps.
- Cache compare is a full-width equality on both p and q. Order matters: (p, q) swapped is a miss. encrypt_decrypt does not affect cache hits.

Decomposition:
- Shared package rsa_pkg:
  - default WIDTH;
  - FSM state enum rsa_seq_state_t;
  - message-width constant MSG_W = 2*WIDTH.
- One sub-module, rsa_seq_watchdog: counter with clear/enable and a timeout output, parameterised by TIMEOUT_CYCLES.
- The FSM, operand registers and key cache live in the top.

Test Plan:
- Behavioural control model (inverter latency 40, mod_exp latency 300). Job p=113680897410347, q=7999808077935876437321, enc_dec=0, msg=256'h6a3e18f03ab37b0000000000 -> exactly one reset_inverter pulse, then one reset_mod_exp pulse; rsp_valid with rsp_msg equal to the model's msg_out; rsp_error=0.
- Repeat the same p/q with enc_dec=1 and msg = previous result -> no reset_inverter pulse; reset_mod_exp 1 cycle after accept; rsp_msg equals the original message.
- Swap to p=7999808077935876437321, q=113680897410347 -> cache miss, reset_inverter pulsed.
- Model leaves finish stuck high from the prior job for 1 cycle after the pulse -> sequencer ignores it; rsp_valid arrives only after the true finish.
- TIMEOUT_CYCLES=64, model never raises mod_exp_finish -> rsp_valid with rsp_error=1, rsp_msg=0 at cycle 64 of EXP_WAIT. The next identical-key job pulses reset_inverter (cache invalidated).
- Hold rsp_ready=0 for 20 cycles, then pulse it -> rsp_msg stable throughout and req_ready=0 until the handshake. Separately, assert reset during INV_WAIT -> all outputs 0 next cycle and req_ready=1.
